// File: rtl/lingret_alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
// LINGRET_ALU_MUL_EN selects the iterative multiplier build.
package lingret_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/lingret_alu_mul.sv
// Iterative shift-add multiplier, one partial product per enabled cycle.
// Only instantiated when LINGRET_ALU_MUL_EN is defined.
module lingret_alu_mul
    import lingret_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (ena) begin
            if (start) begin
                product <= '0;
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                cnt     <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
            end else if (busy) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // last of WIDTH iterations
                if (cnt == SHW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lingret_alu_seq.sv
// Handshaked registered ALU with one transaction in flight.
// Define LINGRET_ALU_MUL_EN to enable the multi-cycle multiplier for op 111.
module lingret_alu_seq
    import lingret_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] res;
    logic             f_c;
    logic             f_ov;
    logic             f_il;

    assign in_ready = ena && (state == S_IDLE);

`ifdef LINGRET_ALU_MUL_EN
    logic               is_mul;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul    = (op_e'(op) == OP_MUL);
    assign mul_start = in_ready && in_valid && is_mul;

    lingret_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign b_neg = ~b_q + 1'b1;

    always_comb begin
        res  = '0;
        f_c  = 1'b0;
        f_ov = 1'b0;
        f_il = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res  = sum[MSB:0];
                f_c  = sum[WIDTH];
                f_ov = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                // borrow out of the extended subtract is exactly a < b
                res  = diff[MSB:0];
                f_c  = diff[WIDTH];
                f_ov = (a_q[MSB] == b_neg[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_SHL: res = a_q << b_q[SHW-1:0];
            OP_SHR: res = a_q >> b_q[SHW-1:0];
            OP_MUL: begin
`ifdef LINGRET_ALU_MUL_EN
                res = mul_prod[MSB:0];
                f_c = |mul_prod[2*WIDTH-1:WIDTH];
`else
                f_il = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (ena) begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_e'(op);
                        a_q  <= a;
                        b_q  <= b;
`ifdef LINGRET_ALU_MUL_EN
                        state <= is_mul ? S_EXEC : S_DONE;
`else
                        state <= S_DONE;
`endif
                    end
                end
                S_EXEC: begin
`ifdef LINGRET_ALU_MUL_EN
                    if (mul_done) begin
                        result    <= res;
                        carry     <= f_c;
                        zero      <= (res == '0);
                        overflow  <= f_ov;
                        illegal   <= f_il;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
`else
                    state <= S_DONE;
`endif
                end
                S_DONE: begin
                    // first DONE cycle registers the single-cycle result
                    if (!out_valid) begin
                        result    <= res;
                        carry     <= f_c;
                        zero      <= (res == '0);
                        overflow  <= f_ov;
                        illegal   <= f_il;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lingret_alu_seq.sv
// Scoreboard bench for lingret_alu_seq: directed spec vectors plus random ops.
// Expectations follow LINGRET_ALU_MUL_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_lingret_alu_seq;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       ov;
        logic       il;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
    logic       illegal;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   rand_mode = 0;
    exp_t sb[$];

    lingret_alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built from the arithmetic rules on plain integers
    function automatic exp_t model(int o, int x, int y);
        exp_t e;
        int r = 0;
        int bp = 0;
        bit c = 0;
        bit ov = 0;
        bit il = 0;
        case (o)
            0: begin r = x + y; c = (r > 255); bp = y; end
            1: begin r = x - y; c = (x < y); bp = (256 - y) % 256; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = x << (y % 8);
            6: r = x >> (y % 8);
            default: begin
`ifdef LINGRET_ALU_MUL_EN
                r = x * y;
                c = (r > 255);
`else
                r = 0;
                il = 1;
`endif
            end
        endcase
        r = r & 255;
        if (o <= 1)
            ov = ((x >= 128) == (bp >= 128)) && ((r >= 128) != (x >= 128));
        e.res = r[7:0];
        e.c = c;
        e.z = (r == 0);
        e.ov = ov;
        e.il = il;
        return e;
    endfunction

    function automatic exp_t mk(int r, bit c, bit z, bit ov, bit il);
        exp_t e;
        e.res = r[7:0];
        e.c = c;
        e.z = z;
        e.ov = ov;
        e.il = il;
        return e;
    endfunction

    // Monitor: result hold while stalled, scoreboard pop on handshake
    bit       last_valid = 0;
    bit       last_cons = 0;
    exp_t     last_out;
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {result, carry, zero, overflow, illegal};
        if (!rst_n) begin
            last_valid = 0;
            last_cons = 0;
        end else begin
            if (last_valid && !last_cons) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", {20'b0, cur}, {20'b0, last_out});
            end
            last_valid = out_valid;
            last_cons = out_valid && out_ready && ena;
            last_out = cur;
            if (last_cons) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out", {20'b0, cur}, {20'b0, e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
                ena = ($urandom_range(0, 7) != 0);
            end
        end
    end

    task automatic issue(int o, int x, int y, exp_t e);
        int n = 0;
        op = o[2:0];
        a = x[7:0];
        b = y[7:0];
        in_valid = 1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'd1, 32'd0);
                in_valid = 0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        acc_cyc = cyc;
        in_valid = 0;
        a = $urandom;
        b = $urandom;
        op = $urandom;
    endtask

    task automatic wait_valid(string name, int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, cyc - acc_cyc, lat);
    endtask

    initial begin
        rst_n = 0;
        ena = 0;
        in_valid = 0;
        op = 0;
        a = 0;
        b = 0;
        out_ready = 1;
        #2;
        chk("rst_ready_ena0", {31'b0, in_ready}, 32'd0);
        ena = 1;
        #1;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_outs", {19'b0, out_valid, result, carry, zero, overflow, illegal},
            32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        issue(0, 8'hF0, 8'h20, mk(8'h10, 1, 0, 0, 0));
        wait_valid("lat_add", 1);
        issue(1, 8'h80, 8'h01, mk(8'h7F, 0, 0, 1, 0));
        wait_valid("lat_sub", 1);
        issue(1, 8'h05, 8'h05, mk(8'h00, 0, 1, 0, 0));
        wait_valid("lat_sub0", 1);
        issue(5, 8'h81, 8'hF9, mk(8'h02, 0, 0, 0, 0));
        wait_valid("lat_shl", 1);
        issue(6, 8'h80, 8'h0F, mk(8'h01, 0, 0, 0, 0));
        wait_valid("lat_shr", 1);
`ifdef LINGRET_ALU_MUL_EN
        issue(7, 8'h12, 8'h10, mk(8'h20, 1, 0, 0, 0));
        wait_valid("lat_mul", 9);
`else
        issue(7, 8'h12, 8'h10, mk(8'h00, 0, 1, 0, 1));
        wait_valid("lat_mul", 1);
`endif

        // backpressure
        @(posedge clk);
        #1;
        out_ready = 0;
        issue(2, 8'hCC, 8'h0F, model(2, 8'hCC, 8'h0F));
        wait_valid("lat_bp", 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;

        // ena low after accept stretches latency cycle for cycle
        issue(4, 8'h5A, 8'hFF, model(4, 8'h5A, 8'hFF));
        ena = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("ena_low_ready", {31'b0, in_ready}, 32'd0);
        ena = 1;
        wait_valid("lat_ena", 4);

        // reset mid-operation discards the transaction
        @(posedge clk);
        #1;
        out_ready = 0;
`ifdef LINGRET_ALU_MUL_EN
        issue(7, 8'hFF, 8'hFF, model(7, 8'hFF, 8'hFF));
        repeat (3) @(posedge clk);
`else
        issue(0, 8'h01, 8'h01, model(0, 8'h01, 8'h01));
        repeat (2) @(posedge clk);
`endif
        #1;
        rst_n = 0;
        void'(sb.pop_back());
        #1;
        chk("mid_rst_outs", {19'b0, out_valid, result, carry, zero, overflow, illegal},
            32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        issue(3, 8'hA0, 8'h05, mk(8'hA5, 0, 0, 0, 0));
        wait_valid("lat_after_rst", 1);

        // random phase with random backpressure and enable
        rand_mode = 1;
        for (int i = 0; i < 80; i++) begin
            int o;
            int x;
            int y;
            o = $urandom_range(0, 7);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            issue(o, x, y, model(o, x, y));
        end
        rand_mode = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        ena = 1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
